// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - circular retire trace buffer with valid/ready drain and cycle watchdog
// Optional: TRACE_X0_FILTER_EN drops register writes to x0 from capture.
module retire_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 2000,
    parameter int OVERWRITE  = 0,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write,
    input  logic [4:0]               rd_idx,
    input  logic [31:0]              wb_data,
    input  logic                     mem_write,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_data,
    input  logic [31:0]              pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [97:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         cycles,
    output logic                     timeout,
    output logic                     done,
    output logic                     err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX_CYCLES - 1);

    logic [97:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [PW:0]   count_next;
    logic [97:0]   entry, head_next;
    logic          ev_reg, push, pop, full, do_write, grow, drop;

    always_comb begin
        ev_reg = reg_write;
`ifdef TRACE_X0_FILTER_EN
        ev_reg = reg_write && (rd_idx != 5'd0);
`else
        ev_reg = reg_write;
`endif
        push  = !done && (ev_reg || mem_write);
        entry = ev_reg ? {2'b01, pc, {27'b0, rd_idx}, wb_data}
                       : {2'b10, pc, mem_addr, mem_data};
        full  = (count == (PW+1)'(DEPTH));
        pop   = out_valid && out_ready;
        // A full buffer only takes a push if a pop frees a slot or overwrite is enabled.
        do_write   = push && (!full || pop || (OVERWRITE != 0));
        drop       = push && full && !pop;
        grow       = do_write && (!full || pop);
        rd_next    = rd_ptr + PW'(pop || (do_write && full && !pop));
        count_next = count + (PW+1)'(grow) - (PW+1)'(pop);
        // The head may be the entry written on this very edge.
        if (count_next == '0)
            head_next = '0;
        else if (do_write && (wr_ptr == rd_next))
            head_next = entry;
        else
            head_next = mem[rd_next];
    end

    assign out_valid = (count != '0);

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_data <= '0;
            drop_cnt <= '0;
            cycles   <= '0;
            timeout  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(do_write);
            rd_ptr   <= rd_next;
            count    <= count_next;
            out_data <= head_next;
            if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
            if (!done && ev_reg && mem_write)
                err <= 1'b1;
            if (cycles != MAX_C)
                cycles <= cycles + 1'b1;
            timeout <= (cycles == LAST_C);
            if (cycles == LAST_C)
                done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - randomized checks of three buffer configurations against a queue model
module tb_retire_trace_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reg_write = 1'b0, mem_write = 1'b0, out_ready = 1'b0;
    logic [4:0]  rd_idx = '0;
    logic [31:0] wb_data = '0, mem_addr = '0, mem_data = '0, pc = '0;

    logic        ov_w   [3];
    logic [97:0] od_w   [3];
    logic [4:0]  cnt_w  [3];
    logic [15:0] drop_w [3];
    logic [15:0] cyc_w  [3];
    logic        to_w   [3];
    logic        done_w [3];
    logic        err_w  [3];

    int errors = 0;
    int checks = 0;

    logic [97:0] mq [3][$];
    int  mdrop [3];
    int  mcyc  [3];
    bit  mdone [3];
    bit  merr  [3];
    bit  mto   [3];
    int  mmax  [3] = '{2000, 2000, 50};
    bit  movw  [3] = '{1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    retire_trace_buffer #(.DEPTH(16), .MAX_CYCLES(2000), .OVERWRITE(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .reg_write(reg_write), .rd_idx(rd_idx), .wb_data(wb_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .pc(pc),
        .out_valid(ov_w[0]), .out_ready(out_ready), .out_data(od_w[0]), .count(cnt_w[0]),
        .drop_cnt(drop_w[0]), .cycles(cyc_w[0]), .timeout(to_w[0]), .done(done_w[0]), .err(err_w[0]));
    retire_trace_buffer #(.DEPTH(16), .MAX_CYCLES(2000), .OVERWRITE(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .reg_write(reg_write), .rd_idx(rd_idx), .wb_data(wb_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .pc(pc),
        .out_valid(ov_w[1]), .out_ready(out_ready), .out_data(od_w[1]), .count(cnt_w[1]),
        .drop_cnt(drop_w[1]), .cycles(cyc_w[1]), .timeout(to_w[1]), .done(done_w[1]), .err(err_w[1]));
    retire_trace_buffer #(.DEPTH(16), .MAX_CYCLES(50), .OVERWRITE(0), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .reg_write(reg_write), .rd_idx(rd_idx), .wb_data(wb_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .pc(pc),
        .out_valid(ov_w[2]), .out_ready(out_ready), .out_data(od_w[2]), .count(cnt_w[2]),
        .drop_cnt(drop_w[2]), .cycles(cyc_w[2]), .timeout(to_w[2]), .done(done_w[2]), .err(err_w[2]));

    // Drive one cycle of inputs, advance the reference model by the same edge, then sample after it.
    task automatic step(input logic rst, input logic rw, input logic [4:0] rd, input logic [31:0] wb,
                        input logic mw, input logic [31:0] ma, input logic [31:0] md,
                        input logic [31:0] pc_i, input logic rdy);
        logic [97:0] e;
        bit evr, ev, popping;
        reset = rst; reg_write = rw; rd_idx = rd; wb_data = wb;
        mem_write = mw; mem_addr = ma; mem_data = md; pc = pc_i; out_ready = rdy;
`ifdef TRACE_X0_FILTER_EN
        evr = rw && (rd != 5'd0);
`else
        evr = rw;
`endif
        e = evr ? {2'b01, pc_i, 27'b0, rd, wb} : {2'b10, pc_i, ma, md};
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mq[k].delete();
                mdrop[k] = 0; mcyc[k] = 0; mdone[k] = 0; merr[k] = 0; mto[k] = 0;
            end else begin
                popping = rdy && (mq[k].size() > 0);
                ev = !mdone[k] && (evr || mw);
                if (!mdone[k] && evr && mw) merr[k] = 1;
                if (popping) void'(mq[k].pop_front());
                if (ev) begin
                    if (mq[k].size() < 16) begin
                        mq[k].push_back(e);
                    end else begin
                        if (movw[k]) begin
                            void'(mq[k].pop_front());
                            mq[k].push_back(e);
                        end
                        mdrop[k]++;
                    end
                end
                mto[k] = 0;
                if (mcyc[k] < mmax[k]) begin
                    mcyc[k]++;
                    if (mcyc[k] == mmax[k]) begin
                        mto[k] = 1;
                        mdone[k] = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 5'd3, 32'h1234, 1'b1, 32'h40, 32'h99, 32'h8, 1'b0);
        do_reset();
        checks++; if (ov_w[0] !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", ov_w[0]); end
        checks++; if (od_w[0] !== 98'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", od_w[0]); end
        checks++; if (cnt_w[0] !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", cnt_w[0]); end
        checks++; if (cyc_w[0] !== 16'd0) begin errors++; $display("FAIL reset_cycles: got %0d exp 0", cyc_w[0]); end
        checks++; if ({to_w[0], done_w[0], err_w[0]} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b exp 000", {to_w[0], done_w[0], err_w[0]}); end
        checks++; if (drop_w[0] !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d exp 0", drop_w[0]); end
    endtask

    task automatic test_single();
        logic [97:0] exp_e;
        exp_e = {2'b01, 32'h10, 32'h5, 32'hFFFFFFFC};
        do_reset();
        step(1'b0, 1'b1, 5'd5, 32'hFFFFFFFC, 1'b0, 32'd0, 32'd0, 32'h10, 1'b1);
        checks++; if (ov_w[0] !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", ov_w[0]); end
        checks++; if (od_w[0] !== exp_e) begin errors++; $display("FAIL single_data: got %h exp %h", od_w[0], exp_e); end
        checks++; if (cnt_w[0] !== 5'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", cnt_w[0]); end
        idle(1'b1);
        checks++; if (cnt_w[0] !== 5'd0 || ov_w[0] !== 1'b0) begin
            errors++; $display("FAIL single_pop: got count %0d valid %b exp 0 0", cnt_w[0], ov_w[0]); end
        idle(1'b1);
        checks++; if (cnt_w[0] !== 5'd0) begin errors++; $display("FAIL empty_pop: got %0d exp 0", cnt_w[0]); end
    endtask

    task automatic test_fill();
        logic [31:0] a [20];
        do_reset();
        for (int i = 0; i < 20; i++) begin
            a[i] = $urandom;
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, a[i], $urandom, 32'h100 + 32'(i*4), 1'b0);
        end
        checks++; if (cnt_w[0] !== 5'd16 || drop_w[0] !== 16'd4) begin
            errors++; $display("FAIL fill_drop0: got count %0d drop %0d exp 16 4", cnt_w[0], drop_w[0]); end
        checks++; if (cnt_w[1] !== 5'd16 || drop_w[1] !== 16'd4) begin
            errors++; $display("FAIL fill_drop1: got count %0d drop %0d exp 16 4", cnt_w[1], drop_w[1]); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (od_w[0][63:32] !== a[i]) begin
                errors++; $display("FAIL drain0_%0d: got %h exp %h", i, od_w[0][63:32], a[i]); end
            checks++; if (od_w[1][63:32] !== a[i+4]) begin
                errors++; $display("FAIL drain1_%0d: got %h exp %h", i, od_w[1][63:32], a[i+4]); end
            idle(1'b1);
        end
        checks++; if (cnt_w[0] !== 5'd0 || cnt_w[1] !== 5'd0) begin
            errors++; $display("FAIL drain_empty: got %0d %0d exp 0 0", cnt_w[0], cnt_w[1]); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] last;
        do_reset();
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'(i), 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'hCAFE0001, 32'h55, 32'h20, 1'b1);
        checks++; if (cnt_w[0] !== 5'd16 || drop_w[0] !== 16'd0) begin
            errors++; $display("FAIL pushpop: got count %0d drop %0d exp 16 0", cnt_w[0], drop_w[0]); end
        last = '0;
        for (int i = 0; i < 16; i++) begin
            last = od_w[0][63:32];
            idle(1'b1);
        end
        checks++; if (last !== 32'hCAFE0001) begin
            errors++; $display("FAIL pushpop_tail: got %h exp cafe0001", last); end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            step(1'b0, (r < 4) || (r == 9), 5'($urandom), $urandom, (r >= 4 && r < 7) || (r == 9),
                 $urandom, $urandom, $urandom, $urandom_range(0, 2) == 0);
            for (int k = 0; k < 2; k++) begin
                checks++; if (cnt_w[k] !== 5'(mq[k].size()) || drop_w[k] !== 16'(mdrop[k]) || err_w[k] !== merr[k]) begin
                    errors++; $display("FAIL rand_state%0d: got cnt %0d drop %0d err %b exp %0d %0d %b",
                                       k, cnt_w[k], drop_w[k], err_w[k], mq[k].size(), mdrop[k], merr[k]); end
                checks++; if (od_w[k] !== ((mq[k].size() > 0) ? mq[k][0] : 98'd0)) begin
                    errors++; $display("FAIL rand_data%0d: got %h exp %h", k, od_w[k],
                                       (mq[k].size() > 0) ? mq[k][0] : 98'd0); end
            end
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            step(1'b0, 1'b1, 5'd9, $urandom, 1'b0, 32'd0, 32'd0, 32'(n), $urandom_range(0, 3) == 0);
            if (to_w[2]) pulses++;
            checks++; if (to_w[2] !== mto[2] || done_w[2] !== mdone[2] || cnt_w[2] !== 5'(mq[2].size())
                          || cyc_w[2] !== 16'(mcyc[2])) begin
                errors++; $display("FAIL timeout_step%0d: got to %b done %b cnt %0d cyc %0d exp %b %b %0d %0d", n,
                                   to_w[2], done_w[2], cnt_w[2], cyc_w[2], mto[2], mdone[2], mq[2].size(), mcyc[2]); end
        end
        checks++; if (pulses != 1 || cyc_w[2] !== 16'd50 || done_w[2] !== 1'b1) begin
            errors++; $display("FAIL timeout_once: got pulses %0d cycles %0d done %b exp 1 50 1", pulses, cyc_w[2], done_w[2]); end
        for (int n = 0; n < 20; n++) begin
            checks++; if (od_w[2] !== ((mq[2].size() > 0) ? mq[2][0] : 98'd0)) begin
                errors++; $display("FAIL timeout_drain%0d: got %h exp %h", n, od_w[2], (mq[2].size() > 0) ? mq[2][0] : 98'd0); end
            step(1'b0, 1'b1, 5'd9, $urandom, 1'b1, $urandom, $urandom, 32'd0, 1'b1);
        end
        checks++; if (cnt_w[2] !== 5'd0) begin errors++; $display("FAIL timeout_empty: got %0d exp 0", cnt_w[2]); end
    endtask

    task automatic test_both();
        do_reset();
        step(1'b0, 1'b1, 5'd7, 32'hA5A5, 1'b1, 32'h80, 32'h33, 32'h44, 1'b0);
        checks++; if (od_w[0][97:96] !== 2'b01 || err_w[0] !== 1'b1) begin
            errors++; $display("FAIL both_kind: got kind %b err %b exp 01 1", od_w[0][97:96], err_w[0]); end
        do_reset();
        checks++; if (err_w[0] !== 1'b0 || cnt_w[0] !== 5'd0 || od_w[0] !== 98'd0) begin
            errors++; $display("FAIL both_reset: got err %b cnt %0d data %h exp 0", err_w[0], cnt_w[0], od_w[0]); end
`ifdef TRACE_X0_FILTER_EN
        step(1'b0, 1'b1, 5'd0, 32'h77, 1'b0, 32'd0, 32'd0, 32'h4, 1'b0);
        checks++; if (cnt_w[0] !== 5'd0 || drop_w[0] !== 16'd0) begin
            errors++; $display("FAIL x0_filter: got cnt %0d drop %0d exp 0 0", cnt_w[0], drop_w[0]); end
        step(1'b0, 1'b1, 5'd0, 32'h77, 1'b1, 32'h90, 32'h11, 32'h8, 1'b0);
        checks++; if (od_w[0][97:96] !== 2'b10 || err_w[0] !== 1'b0) begin
            errors++; $display("FAIL x0_mem: got kind %b err %b exp 10 0", od_w[0][97:96], err_w[0]); end
`else
        step(1'b0, 1'b1, 5'd0, 32'h77, 1'b0, 32'd0, 32'd0, 32'h4, 1'b0);
        checks++; if (cnt_w[0] !== 5'd1 || od_w[0] !== {2'b01, 32'h4, 32'h0, 32'h77}) begin
            errors++; $display("FAIL x0_capture: got cnt %0d data %h exp 1", cnt_w[0], od_w[0]); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_push_pop();
        test_random();
        test_timeout();
        test_both();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
